// File: rtl/uart_rx_os_if.sv
// Receive-word handshake between the UART receiver and its consumer.
// The receiver drives the word, the valid flag and the error flags.
// The consumer returns rd_ack.
interface uart_rx_os_if #(
   parameter int DATA_BITS = 8
);
   logic                 rd_ack;
   logic [DATA_BITS-1:0] data_out;
   logic                 data_valid;
   logic                 frame_err;
   logic                 parity_err;
   logic                 overrun;

   modport master (
      input  rd_ack,
      output data_out, data_valid, frame_err, parity_err, overrun
   );

   modport slave (
      output rd_ack,
      input  data_out, data_valid, frame_err, parity_err, overrun
   );
endinterface

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver. RX is sampled once per ENABLE strobe, and each
// bit is decided by a 3-sample majority vote around the bit centre.
// Received words are held in a register with a valid/ack handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a low level on the synchronised line
// START    | inside the start bit; a high vote means it was a glitch
// DATA     | shifting in DATA_BITS data bits, LSB first
// PARITY   | checking the parity bit (only when PARITY_EN=1)
// STOP     | checking STOP_BITS stop bits; the last vote loads the word
module uart_rx_os #(
   parameter int OVS        = 5,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic          clk,
   input  logic          res,
   input  logic          ENABLE,
   input  logic          RX,
   output logic          busy,
   uart_rx_os_if.master  bus
);

   localparam int SW = $clog2(OVS);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [SW-1:0] S_LAST = SW'(OVS - 1);
   localparam logic [SW-1:0] S_CM1  = SW'(OVS / 2 - 1);
   localparam logic [SW-1:0] S_C    = SW'(OVS / 2);
   localparam logic [SW-1:0] S_CP1  = SW'(OVS / 2 + 1);
   localparam logic [BW-1:0] B_DATA      = BW'(DATA_BITS);
   localparam logic [BW-1:0] B_STOP_LAST = BW'(STOP_BITS - 1);
   localparam logic          P_ODD       = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   logic                 r_rx_m, r_rx_s;
   state_t               r_state, w_state;
   logic [SW-1:0]        r_s, w_s;
   logic [BW-1:0]        r_bit, w_bit;
   logic                 r_smp0, w_smp0, r_smp1, w_smp1;
   logic [DATA_BITS-1:0] r_shift, w_shift;
   logic                 r_perr, w_perr, r_ferr, w_ferr;
   logic                 w_load;
   logic [DATA_BITS-1:0] r_data;
   logic                 r_dv, r_fe_o, r_pe_o, r_ovr, r_busy;

   logic w_dec_strb, w_dec, w_wrap;

   assign w_dec_strb = (r_s == S_CP1);
   assign w_wrap     = (r_s == S_LAST);
   assign w_dec      = (r_smp0 & r_smp1) | (r_smp0 & r_rx_s) | (r_smp1 & r_rx_s);

   // Two-flop synchroniser; it idles high so reset does not look like a start bit.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_rx_m <= 1'b1;
         r_rx_s <= 1'b1;
      end else begin
         r_rx_m <= RX;
         r_rx_s <= r_rx_m;
      end
   end

   // FSM and counter registers; they only move when the comb logic says so.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_state <= ST_IDLE;
         r_s     <= '0;
         r_bit   <= '0;
         r_smp0  <= 1'b1;
         r_smp1  <= 1'b1;
         r_shift <= '0;
         r_perr  <= 1'b0;
         r_ferr  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state;
         r_s     <= w_s;
         r_bit   <= w_bit;
         r_smp0  <= w_smp0;
         r_smp1  <= w_smp1;
         r_shift <= w_shift;
         r_perr  <= w_perr;
         r_ferr  <= w_ferr;
         r_busy  <= (w_state != ST_IDLE);
      end
   end

   // Next-state logic: everything holds unless ENABLE strobes.
   always_comb begin
      w_state = r_state;
      w_s     = r_s;
      w_bit   = r_bit;
      w_smp0  = r_smp0;
      w_smp1  = r_smp1;
      w_shift = r_shift;
      w_perr  = r_perr;
      w_ferr  = r_ferr;
      w_load  = 1'b0;
      if (ENABLE) begin
         w_s = w_wrap ? '0 : r_s + SW'(1);
         if (r_s == S_CM1) w_smp0 = r_rx_s;
         if (r_s == S_C)   w_smp1 = r_rx_s;
         case (r_state)
            ST_IDLE: begin
               w_s = '0;
               if (!r_rx_s) begin
                  w_state = ST_START;
                  w_s     = SW'(1);
                  w_bit   = '0;
                  w_perr  = 1'b0;
                  w_ferr  = 1'b0;
               end
            end
            ST_START: begin
               if (w_dec_strb && w_dec) begin
                  w_state = ST_IDLE;
                  w_s     = '0;
               end else if (w_wrap) begin
                  w_state = ST_DATA;
                  w_bit   = '0;
               end
            end
            ST_DATA: begin
               if (w_dec_strb) begin
                  w_shift = {w_dec, r_shift[DATA_BITS-1:1]};
                  w_bit   = r_bit + BW'(1);
               end
               if (w_wrap && (w_bit == B_DATA)) begin
                  w_state = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                  w_bit   = '0;
               end
            end
            ST_PARITY: begin
               if (w_dec_strb) w_perr = ((^r_shift) ^ w_dec) != P_ODD;
               if (w_wrap) begin
                  w_state = ST_STOP;
                  w_bit   = '0;
               end
            end
            ST_STOP: begin
               if (w_dec_strb) begin
                  w_ferr = r_ferr | ~w_dec;
                  // Leave on the last vote rather than at s=OVS-1 so the next start edge is caught early.
                  if (r_bit == B_STOP_LAST) begin
                     w_load  = 1'b1;
                     w_state = ST_IDLE;
                     w_s     = '0;
                  end else begin
                     w_bit = r_bit + BW'(1);
                  end
               end
            end
            default: begin
               w_state = ST_IDLE;
               w_s     = '0;
            end
         endcase
      end
   end

   // Holding register and handshake; a coincident ack wins over overrun.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         r_data <= '0;
         r_dv   <= 1'b0;
         r_fe_o <= 1'b0;
         r_pe_o <= 1'b0;
         r_ovr  <= 1'b0;
      end else if (w_load) begin
         r_data <= r_shift;
         r_fe_o <= w_ferr;
         r_pe_o <= r_perr;
         r_dv   <= 1'b1;
         if (r_dv) r_ovr <= ~bus.rd_ack;
      end else if (r_dv && bus.rd_ack) begin
         r_dv  <= 1'b0;
         r_ovr <= 1'b0;
      end
   end

   assign bus.data_out   = r_data;
   assign bus.data_valid = r_dv;
   assign bus.frame_err  = r_fe_o;
   assign bus.parity_err = r_pe_o;
   assign bus.overrun    = r_ovr;
   assign busy           = r_busy;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: an 8N1 receiver and an 8E1 receiver share clock and reset.
module tb_uart_rx_os;

   logic clk = 1'b0;
   logic res, enable, rx0, rx1, busy0, busy1;
   int   checks = 0;
   int   errors = 0;

   uart_rx_os_if #(.DATA_BITS(8)) bus0 ();
   uart_rx_os_if #(.DATA_BITS(8)) bus1 ();

   uart_rx_os #(.OVS(5), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
      .clk(clk), .res(res), .ENABLE(enable), .RX(rx0), .busy(busy0), .bus(bus0)
   );

   uart_rx_os #(.OVS(5), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
      .clk(clk), .res(res), .ENABLE(enable), .RX(rx1), .busy(busy1), .bus(bus1)
   );

   always #5 clk = ~clk;

   // One bit is 5 clk. gpos selects a frame bit whose centre sample is inverted (-1 means none).
   // The task returns one edge before the stop-bit decision.
   task automatic send_frame(input bit sel, input logic [7:0] d, input bit par_en,
                             input bit par_val, input bit stop_val, input int gpos);
      int   n;
      logic v;
      n = par_en ? 11 : 10;
      for (int i = 0; i < n; i++) begin
         if (i == 0)                 v = 1'b0;
         else if (i <= 8)            v = d[i-1];
         else if (par_en && i == 9)  v = par_val;
         else                        v = stop_val;
         for (int j = 0; j < 5; j++) begin
            if (sel) rx1 = (i == gpos && j == 2) ? ~v : v;
            else     rx0 = (i == gpos && j == 2) ? ~v : v;
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic idle(input int n);
      rx0 = 1'b1;
      rx1 = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic ack0();
      bus0.rd_ack = 1'b1;
      @(posedge clk); #1;
      bus0.rd_ack = 1'b0;
   endtask

   task automatic test_reset();
      res = 1'b0; enable = 1'b1; rx0 = 1'b1; rx1 = 1'b1;
      bus0.rd_ack = 1'b0; bus1.rd_ack = 1'b0;
      repeat (3) @(posedge clk); #1;
      res = 1'b1;
      repeat (4) @(posedge clk); #1;
      checks++; if (bus0.data_out !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", bus0.data_out); end
      checks++; if ({bus0.data_valid, bus0.frame_err, bus0.parity_err, bus0.overrun, busy0} !== 5'b0) begin
         errors++; $display("FAIL reset_flags got=%b exp=00000", {bus0.data_valid, bus0.frame_err, bus0.parity_err, bus0.overrun, busy0}); end
   endtask

   task automatic test_basic();
      send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, -1);
      checks++; if (bus0.data_valid !== 1'b0) begin errors++; $display("FAIL basic_dv_early got=%b exp=0", bus0.data_valid); end
      checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL basic_busy got=%b exp=1", busy0); end
      @(posedge clk); #1;
      checks++; if (bus0.data_valid !== 1'b1) begin errors++; $display("FAIL basic_dv got=%b exp=1", bus0.data_valid); end
      checks++; if (bus0.data_out !== 8'hA5) begin errors++; $display("FAIL basic_data got=%h exp=a5", bus0.data_out); end
      checks++; if ({bus0.frame_err, bus0.parity_err, bus0.overrun, busy0} !== 4'b0) begin
         errors++; $display("FAIL basic_flags got=%b exp=0000", {bus0.frame_err, bus0.parity_err, bus0.overrun, busy0}); end
      idle(4);
      ack0();
      checks++; if (bus0.data_valid !== 1'b0) begin errors++; $display("FAIL basic_ack got=%b exp=0", bus0.data_valid); end
      idle(5);
   endtask

   task automatic test_glitch();
      rx0 = 1'b0;
      repeat (2) @(posedge clk); #1;
      rx0 = 1'b1;
      @(posedge clk); #1;
      checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL glitch_busy got=%b exp=1", busy0); end
      repeat (3) @(posedge clk); #1;
      checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL glitch_idle got=%b exp=0", busy0); end
      idle(60);
      checks++; if (bus0.data_valid !== 1'b0) begin errors++; $display("FAIL glitch_dv got=%b exp=0", bus0.data_valid); end
   endtask

   task automatic test_majority();
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 3);
      @(posedge clk); #1;
      checks++; if (bus0.data_out !== 8'h3C) begin errors++; $display("FAIL maj_data got=%h exp=3c", bus0.data_out); end
      checks++; if (bus0.frame_err !== 1'b0) begin errors++; $display("FAIL maj_ferr got=%b exp=0", bus0.frame_err); end
      idle(5);
      ack0();
   endtask

   task automatic test_parity_frame();
      send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1, -1);
      @(posedge clk); #1;
      checks++; if (bus1.data_out !== 8'h07) begin errors++; $display("FAIL par_data got=%h exp=07", bus1.data_out); end
      checks++; if ({bus1.data_valid, bus1.parity_err, bus1.frame_err} !== 3'b110) begin
         errors++; $display("FAIL par_err got=%b exp=110", {bus1.data_valid, bus1.parity_err, bus1.frame_err}); end
      idle(5);
      bus1.rd_ack = 1'b1; @(posedge clk); #1; bus1.rd_ack = 1'b0;
      send_frame(1'b1, 8'h01, 1'b1, 1'b1, 1'b0, -1);
      @(posedge clk); #1;
      rx1 = 1'b1;
      checks++; if (bus1.data_out !== 8'h01) begin errors++; $display("FAIL ferr_data got=%h exp=01", bus1.data_out); end
      checks++; if ({bus1.data_valid, bus1.parity_err, bus1.frame_err, bus1.overrun} !== 4'b1010) begin
         errors++; $display("FAIL ferr_flags got=%b exp=1010", {bus1.data_valid, bus1.parity_err, bus1.frame_err, bus1.overrun}); end
      idle(20);
      checks++; if ({bus1.data_valid, bus1.data_out, busy1} !== {1'b1, 8'h01, 1'b0}) begin
         errors++; $display("FAIL ferr_resync got=%b exp=1_00000001_0", {bus1.data_valid, bus1.data_out, busy1}); end
   endtask

   task automatic test_overrun();
      send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, -1); idle(5);
      send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, -1); idle(5);
      checks++; if ({bus0.data_valid, bus0.overrun, bus0.data_out} !== {2'b11, 8'h22}) begin
         errors++; $display("FAIL ovr_set got=%b exp=11_00100010", {bus0.data_valid, bus0.overrun, bus0.data_out}); end
      ack0();
      checks++; if ({bus0.data_valid, bus0.overrun} !== 2'b00) begin
         errors++; $display("FAIL ovr_ack got=%b exp=00", {bus0.data_valid, bus0.overrun}); end
      ack0();
      checks++; if ({bus0.data_valid, bus0.overrun} !== 2'b00) begin
         errors++; $display("FAIL ack_idle got=%b exp=00", {bus0.data_valid, bus0.overrun}); end
      send_frame(1'b0, 8'h44, 1'b0, 1'b0, 1'b1, -1); idle(5);
      send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1, -1);
      bus0.rd_ack = 1'b1; @(posedge clk); #1; bus0.rd_ack = 1'b0;
      checks++; if ({bus0.data_valid, bus0.overrun, bus0.data_out} !== {2'b10, 8'h55}) begin
         errors++; $display("FAIL ack_load got=%b exp=10_01010101", {bus0.data_valid, bus0.overrun, bus0.data_out}); end
      idle(5);
      send_frame(1'b0, 8'h66, 1'b0, 1'b0, 1'b1, -1); idle(5);
      checks++; if (bus0.overrun !== 1'b1) begin errors++; $display("FAIL ovr_again got=%b exp=1", bus0.overrun); end
      send_frame(1'b0, 8'h77, 1'b0, 1'b0, 1'b1, -1);
      bus0.rd_ack = 1'b1; @(posedge clk); #1; bus0.rd_ack = 1'b0;
      checks++; if ({bus0.data_valid, bus0.overrun, bus0.data_out} !== {2'b10, 8'h77}) begin
         errors++; $display("FAIL ovr_clear got=%b exp=10_01110111", {bus0.data_valid, bus0.overrun, bus0.data_out}); end
      idle(5);
   endtask

   task automatic test_reset_midframe();
      logic [7:0] d;
      d = 8'h5A;
      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < ((i == 5) ? 4 : 5); j++) begin
            rx0 = (i == 0) ? 1'b0 : d[i-1];
            @(posedge clk); #1;
         end
      end
      checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL mid_busy got=%b exp=1", busy0); end
      res = 1'b0;
      #1;
      checks++; if ({bus0.data_valid, bus0.overrun, bus0.frame_err, bus0.parity_err, busy0, bus0.data_out} !== 13'b0) begin
         errors++; $display("FAIL mid_reset got=%b exp=0", {bus0.data_valid, bus0.overrun, bus0.frame_err, bus0.parity_err, busy0, bus0.data_out}); end
      rx0 = 1'b1;
      repeat (2) @(posedge clk); #1;
      res = 1'b1;
      idle(5);
      send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, -1);
      @(posedge clk); #1;
      checks++; if ({bus0.data_valid, bus0.data_out} !== {1'b1, 8'h5A}) begin
         errors++; $display("FAIL post_reset got=%b exp=1_01011010", {bus0.data_valid, bus0.data_out}); end
      idle(5);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_majority();
      test_parity_frame();
      test_overrun();
      test_reset_midframe();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised oversampling UART receiver. It samples RX once per ENABLE strobe (OVS strobes per bit) and decides each bit by a 3-sample majority vote around the bit centre. Data bits, parity and stop-bit count are configurable. Each received word lands in a holding register with a valid/acknowledge handshake and per-frame error flags. It sits between the baud-tick generator and the UART transmit/control logic.

Parameters:
OVS, 5, samples per bit; legal range 3..16.
DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
PARITY_EN, 0, 1 = a parity bit follows the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN=0.
STOP_BITS, 1, stop bits checked per frame; 1 or 2.

Ports:
clk  in  1  system clock
res  in  1  asynchronous active-low reset
ENABLE  in  1  sample strobe, one clk wide, OVS pulses per bit time
RX  in  1  serial line, asynchronous, idle high
rd_ack  in  1  consumer acknowledge of data_out
data_out  out  DATA_BITS  last received word
data_valid  out  1  data_out holds an unacknowledged word
frame_err  out  1  last delivered word had a 0 in a stop bit
parity_err  out  1  last delivered word failed the parity check
overrun  out  1  sticky; a word was overwritten before it was acknowledged
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, res=0): state IDLE; counters 0; synchroniser flops 1; data_out=0; data_valid, frame_err, parity_err, overrun and busy all 0.
- RX passes through a 2-flop synchroniser (rx_s) before any use; it adds 2 clk of latency.
- All FSM and counter activity advances only on clk edges with ENABLE=1. ENABLE=0 freezes state and counters; it does not abort a frame.
- Sample counter s runs 0..OVS-1 within each bit. c = OVS/2 (integer division). rx_s is captured at s = c-1, c and c+1. The bit decision is the majority of those 3 samples and is taken on the strobe where s = c+1. At s = OVS-1, s wraps to 0 and the next bit begins.
- IDLE: on a strobe with rx_s=0, go to START with s=1; that strobe counts as sample 0.
- START: if the decision is 1 (glitch), return to IDLE with no flags and no output. If it is 0, continue to DATA.
- DATA: DATA_BITS decisions, shifted in LSB first. Then go to PARITY if PARITY_EN=1, otherwise to STOP.
- PARITY: compute the XOR of the data bits and the parity decision. An error is flagged if the result is not equal to PARITY_ODD.
- STOP: STOP_BITS decisions; any 0 sets the frame error. On the decision strobe of the last stop bit, return to IDLE immediately without waiting for s=OVS-1, so the receiver can resync on the next start edge. The word is loaded on this same edge.
- Load edge: data_out, frame_err and parity_err take the new frame's values. data_valid=1 from the next cycle. A frame with errors is still delivered.
- Handshake: rd_ack=1 while data_valid=1 clears data_valid and overrun on the next edge. rd_ack while data_valid=0 has no effect.
- Load while data_valid=1 and rd_ack=0: data_out is overwritten, data_valid stays 1, overrun is set.
- Load and rd_ack on the same edge: the new word is loaded, data_valid stays 1, overrun is not set, and an existing overrun is cleared.
- busy = (state != IDLE), registered.
- Reset mid-frame: the frame is discarded and all outputs return to their reset values.
- Widths: s uses $clog2(OVS) bits and the bit counter uses $clog2(DATA_BITS+1) bits; no overflow is possible within the legal ranges.

Test Plan:
- OVS=5, 8N1, one strobe per clk, RX frame 0xA5 -> data_out=0xA5; data_valid rises 1 clk after the stop-bit decision; frame_err=parity_err=overrun=0.
- RX low for 2 strobes, then high (start glitch) -> FSM returns to IDLE; data_valid stays 0; busy pulses and falls back.
- Frame 0x3C with a single-sample inversion at s=c in bit 2 -> majority vote corrects it; data_out=0x3C.
- PARITY_EN=1, PARITY_ODD=0, frame 0x07 with parity bit 0 -> parity_err=1, data_out=0x07. Then a frame 0x01 with stop bit forced 0 -> frame_err=1.
- Two frames 0x11 and 0x22 with no rd_ack -> data_out=0x22, overrun=1. Then rd_ack for one cycle -> data_valid=0, overrun=0. Repeat with rd_ack coincident with the second load -> overrun stays 0.
- Pull res low during DATA bit 4 -> all outputs 0 immediately. After release, a clean frame 0x5A -> data_out=0x5A.
